ifu_align_buffer: RTL
=====================

Name: ifu_align_buffer

Overview:
- Parametrised instruction-fetch realignment buffer between the fetch port and the decode unit (idu).
- Accepts fetch words of FETCH_BYTES bytes and stores them as a circular queue of 16-bit halfwords.
- Presents one instruction per handshake: 16-bit compressed (low bits != 2'b11) or 32-bit.
- Handles 32-bit instructions that straddle fetch-word boundaries, redirect flushes, and stale fetch drops.

Parameters:
- FETCH_BYTES, 4, bytes per fetch word; power of two, >= 4.
- DEPTH, 4, buffer capacity in fetch words; power of two, >= 2.
- ENABLE_C, 1, 1 = RVC supported; 0 = every instruction is 32-bit.
- RESET_ADDR, 32'h0000_0000, expected fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect; discard all buffered state
- flush_addr  in  32  new expected instruction address, halfword aligned
- fetch_valid  in  1  fetch word offered
- fetch_ready  out  1  buffer can accept a whole fetch word
- fetch_addr  in  32  address of fetch word, FETCH_BYTES aligned
- fetch_data  in  8*FETCH_BYTES  fetch word, little-endian
- instr_valid  out  1  complete instruction at head
- instr_ready  in  1  decode accepts head instruction
- instr_addr  out  32  address of head instruction
- instr_addr_next  out  32  instr_addr + 2 or + 4
- instr_data  out  32  instruction; compressed in [15:0], [31:16] = 0
- instr_compressed  out  1  head instruction is 16-bit
- instr_illegal  out  1  ENABLE_C=0 and head [1:0] != 2'b11

Behaviour:
- Geometry: HW = DEPTH*FETCH_BYTES/2 halfword slots; rd_ptr and wr_ptr wrap modulo HW; count is $clog2(HW+1) bits wide.
- Registers: head_addr (address of slot rd_ptr) and exp_addr (next expected fetch address).
- Reset (async, rst_n=0):
  - count=0, rd_ptr=wr_ptr=0, head_addr=exp_addr=RESET_ADDR.
  - Outputs: instr_valid=0, fetch_ready=1, instr_* data outputs = 0.
  - Reset takes effect immediately, mid-operation included; buffered data is lost.
- fetch_ready = !flush && (HW - count >= FETCH_BYTES/2). It depends on the current count only; a same-cycle pop is not credited.
- Fetch accept (fetch_valid && fetch_ready):
  - If fetch_addr != {exp_addr[31:log2(FETCH_BYTES)], 0}, the word is stale: consumed and dropped, no state change.
  - Otherwise, push halfwords whose address >= exp_addr, lowest address first. Only the first word after a reset or flush can skip halfwords.
  - Then set exp_addr = fetch_addr + FETCH_BYTES, wrapping modulo 2^32.
- Head decode (combinational from buffer state):
  - h0 = slot rd_ptr, h1 = slot rd_ptr+1.
  - is16 = ENABLE_C && h0[1:0] != 2'b11.
  - instr_valid = !flush && (is16 ? count >= 1 : count >= 2).
  - instr_data = is16 ? {16'h0, h0} : {h1, h0}.
  - instr_compressed = is16.
  - instr_illegal = !ENABLE_C && h0[1:0] != 2'b11.
  - instr_addr = head_addr; instr_addr_next = head_addr + (is16 ? 2 : 4).
- Latency: a word accepted in cycle N is visible at the head in cycle N+1. No combinational path from fetch_* to instr_*.
- Pop (instr_valid && instr_ready): rd_ptr and count advance by 1 or 2; head_addr = instr_addr_next.
- Simultaneous push and pop in one cycle: count = count + pushed - popped.
- Straddling 32-bit instruction: instr_valid stays low while only its lower halfword is buffered.
- Flush has priority over everything:
  - That cycle: fetch_ready=0 and instr_valid=0; no push, no pop.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, head_addr=exp_addr=flush_addr.
- Address wrap at 2^32 is modulo; no error.

Test Plan:
- Reset, push addr 0x0, data 0x00A00093, instr_ready=1 -> next cycle instr_valid=1, addr 0x0, data 0x00A00093, compressed=0, addr_next 0x4.
- Push addr 0x0, data 0x45050001 -> two beats: (addr 0x0, data 0x00000001, compressed=1), then (addr 0x2, data 0x00004505, compressed=1); instr_valid=0 on the third cycle.
- Straddle: push 0x00930001 at 0x0 -> c.nop at 0x0, then instr_valid=0. Push 0x000100A0 at 0x4 -> next cycle addr 0x2, data 0x00A00093, then addr 0x6, data 0x00000001.
- Full: DEPTH=4, instr_ready=0, push four 32-bit words -> fetch_ready=0 after the fourth accept. Pop one 32-bit instruction -> fetch_ready=1 the following cycle; fifth word accepted intact.
- Flush with flush_addr 0x102 while buffer holds 3 entries:
  - Flush cycle -> instr_valid=0.
  - Push 0x200 -> dropped.
  - Push 0x100, data 0x00010000 -> head addr 0x102, data 0x00000001.
- ENABLE_C=0, push 0x45050001 -> single beat, data 0x45050001, compressed=0, illegal=1, addr_next 0x4.
- Async reset asserted mid-cycle with 3 entries -> instr_valid=0 and fetch_ready=1 without a clock edge; head_addr = RESET_ADDR after release.

Source files
------------

// File: rtl/ifu_align_buffer.sv
// Instruction-fetch realignment buffer.
// Fetch words are split into 16-bit halfwords and kept in a circular queue;
// the head of the queue is decoded as either a 16-bit compressed or a 32-bit
// instruction and offered to the decode unit one instruction per handshake.
module ifu_align_buffer #(
  parameter int          FETCH_BYTES = 4,
  parameter int          DEPTH       = 4,
  parameter bit          ENABLE_C    = 1'b1,
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [31:0]              i_flush_addr,
  input  logic                     i_fetch_valid,
  output logic                     o_fetch_ready,
  input  logic [31:0]              i_fetch_addr,
  input  logic [8*FETCH_BYTES-1:0] i_fetch_data,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  output logic [31:0]              o_instr_addr,
  output logic [31:0]              o_instr_addr_next,
  output logic [31:0]              o_instr_data,
  output logic                     o_instr_compressed,
  output logic                     o_instr_illegal
);

  // Buffer geometry in halfword slots.
  localparam int HW   = DEPTH * FETCH_BYTES / 2;
  localparam int HPF  = FETCH_BYTES / 2;
  localparam int PW   = $clog2(HW);
  localparam int CW   = $clog2(HW + 1);
  localparam int OFFW = $clog2(FETCH_BYTES);

  logic [15:0]     r_mem [HW];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_head_addr;
  logic [31:0]     r_exp_addr;

  logic [15:0]     w_h0;
  logic [15:0]     w_h1;
  logic            w_is16;
  logic [CW-1:0]   w_free;
  logic [31:0]     w_fetch_base;
  logic [OFFW-1:0] w_exp_off;
  logic [OFFW-2:0] w_skip;
  logic            w_push;
  logic [CW-1:0]   w_push_cnt;
  logic            w_pop;
  logic [CW-1:0]   w_pop_cnt;

  // Head decode, handshake qualification and push/pop sizing.
  always_comb begin
    w_h0         = r_mem[r_rd_ptr];
    w_h1         = r_mem[r_rd_ptr + PW'(1)];
    w_is16       = ENABLE_C && (w_h0[1:0] != 2'b11);
    w_free       = CW'(HW) - r_count;
    o_fetch_ready = !i_flush && (w_free >= CW'(HPF));
    o_instr_valid = !i_flush && (w_is16 ? (r_count >= CW'(1)) : (r_count >= CW'(2)));

    w_fetch_base = {r_exp_addr[31:OFFW], {OFFW{1'b0}}};
    w_exp_off    = r_exp_addr[OFFW-1:0];
    w_skip       = w_exp_off[OFFW-1:1];
    // Only a word at the expected aligned address is kept; anything else is stale.
    w_push       = i_fetch_valid && o_fetch_ready && (i_fetch_addr == w_fetch_base);
    w_push_cnt   = w_push ? (CW'(HPF) - CW'(w_skip)) : '0;

    w_pop        = o_instr_valid && i_instr_ready;
    w_pop_cnt    = !w_pop ? '0 : (w_is16 ? CW'(1) : CW'(2));

    o_instr_data       = w_is16 ? {16'h0000, w_h0} : {w_h1, w_h0};
    o_instr_compressed = w_is16;
    o_instr_illegal    = !ENABLE_C && (w_h0[1:0] != 2'b11);
    o_instr_addr       = r_head_addr;
    o_instr_addr_next  = r_head_addr + (w_is16 ? 32'd2 : 32'd4);
  end

  // Halfword storage: write the accepted halfwords at and above the expected address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < HW; k++) begin
        r_mem[k] <= 16'h0000;
      end
    end else if (w_push) begin
      for (int j = 0; j < HPF; j++) begin
        if ((OFFW-1)'(j) >= w_skip) begin
          r_mem[r_wr_ptr + PW'(j) - PW'(w_skip)] <= i_fetch_data[16*j +: 16];
        end
      end
    end
  end

  // Queue pointers, occupancy and address tracking; flush overrides push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_addr <= RESET_ADDR;
      r_exp_addr  <= RESET_ADDR;
    end else if (i_flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_addr <= i_flush_addr;
      r_exp_addr  <= i_flush_addr;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PW'(w_push_cnt);
        r_exp_addr <= i_fetch_addr + 32'(FETCH_BYTES);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PW'(w_pop_cnt);
        r_head_addr <= o_instr_addr_next;
      end
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

endmodule
